// File: rtl/mux_group_scanner.sv
// rtl/mux_group_scanner.sv - steps the 4-group mux selector over enabled groups and streams captured outputs
module mux_group_scanner #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic [3:0] y,
    output logic [1:0] selector,
    output logic [3:0] out_data,
    output logic [1:0] out_group,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] data_q, data_d;
    logic [1:0] group_q, group_d;
    logic       valid_q, valid_d;

    // {found, index} of the lowest enabled group at or above (incl) / strictly above the given index
    function automatic logic [2:0] next_group(input logic [3:0] m, input logic [1:0] s,
                                              input logic incl);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (incl ? (i >= int'(s)) : (i > int'(s)))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    logic [2:0] first_pick;
    logic [2:0] next_pick;

    always_comb begin
        first_pick = next_group(mask, 2'd0, 1'b1);
        next_pick  = next_group(mask_q, sel_q, 1'b0);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        data_d  = data_q;
        group_d = group_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mask != 4'd0) begin
                        mask_d  = mask;
                        sel_d   = first_pick[1:0];
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = y;
                    group_d = sel_q;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // Output registers stay frozen until the downstream handshake completes
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (next_pick[2]) begin
                        sel_d   = next_pick[1:0];
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 4'd0;
            data_q  <= 4'd0;
            group_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            group_q <= group_d;
            valid_q <= valid_d;
        end
    end

    assign selector  = sel_q;
    assign out_data  = data_q;
    assign out_group = group_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mux_group_scanner.sv
// tb/tb_mux_group_scanner.sv - self-checking bench for mux_group_scanner
module tb_mux_group_scanner;

    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mask;
    logic [3:0] y;
    logic [1:0] selector;
    logic [3:0] out_data;
    logic [1:0] out_group;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    mux_group_scanner #(.DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .y(y),
        .selector(selector), .out_data(out_data), .out_group(out_group),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [3:0] ytab [4];
    always_comb y = ytab[selector];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int sel_bad  = 0;
    logic chk_sel = 1'b0;
    logic [5:0] sb [$];
    int hs_cyc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                check("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("beat", 32'({out_group, out_data}), 32'(sb.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (chk_sel && busy && (selector == 2'd0 || selector == 2'd2)) sel_bad++;
        end
    end

    task automatic pulse_start(input logic [3:0] m);
        start = 1'b1;
        mask  = m;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int hs0;
        int d0;
        logic [3:0] hd;
        logic [1:0] hsel;
        ytab[0] = 4'hA; ytab[1] = 4'h5; ytab[2] = 4'hC; ytab[3] = 4'h3;
        rst = 1'b1; start = 1'b0; mask = 4'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_selector", 32'(selector), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_group", 32'(out_group), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // full scan, ready tied high
        sb.push_back({2'd0, 4'hA}); sb.push_back({2'd1, 4'h5});
        sb.push_back({2'd2, 4'hC}); sb.push_back({2'd3, 4'h3});
        hs_cyc.delete();
        d0 = done_cnt;
        pulse_start(4'b1111);
        check("t1_sel_first", 32'(selector), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done_seen");
        check("t1_done_lat", 32'(done_cyc - t0), 32'd12);
        check("t1_beats", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) begin
            check("t1_first_lat", 32'(hs_cyc[0] - t0), 32'(DWELL));
            for (int i = 1; i < 4; i++) check("t1_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(DWELL + 1));
        end
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // sparse mask
        hs0 = hs_cnt;
        sb.push_back({2'd1, 4'h5}); sb.push_back({2'd3, 4'h3});
        chk_sel = 1'b1;
        pulse_start(4'b1010);
        wait_done("t2_done_seen");
        chk_sel = 1'b0;
        check("t2_sel_skip", 32'(sel_bad), 32'd0);
        check("t2_beats", 32'(hs_cnt - hs0), 32'd2);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // backpressure on group 0
        out_ready = 1'b0;
        sb.push_back({2'd0, 4'hA}); sb.push_back({2'd1, 4'h5});
        pulse_start(4'b0011);
        wait_valid("t3_valid_rise");
        hd = out_data; hsel = selector;
        check("t3_data0", 32'(hd), 32'hA);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'(hd));
            check("t3_hold_sel", 32'(selector), 32'(hsel));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_next_sel", 32'(selector), 32'd1);
        check("t3_valid_drop", 32'(out_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        wait_done("t3_done_seen");
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // empty mask, plus start held through the DONE cycle
        hs0 = hs_cnt;
        start = 1'b1; mask = 4'd0;
        @(posedge clk); #1;
        mask = 4'hF;
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_busy_end", 32'(busy), 32'd0);
        check("t4_done_end", 32'(done), 32'd0);
        check("t4_no_beats", 32'(hs_cnt - hs0), 32'd0);
        @(posedge clk); #1;

        // reset while a beat is pending
        out_ready = 1'b0;
        sb.push_back({2'd0, 4'hA});
        pulse_start(4'b0001);
        wait_valid("t5_valid_rise");
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_selector", 32'(selector), 32'd0);
        check("t5_out_data", 32'(out_data), 32'd0);
        check("t5_out_group", 32'(out_group), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        sb.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        hs0 = hs_cnt;
        sb.push_back({2'd2, 4'hC});
        pulse_start(4'b0100);
        wait_done("t5_done_seen");
        check("t5_beats", 32'(hs_cnt - hs0), 32'd1);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // start and mask disturbed mid-scan
        hs0 = hs_cnt;
        d0 = done_cnt;
        sb.push_back({2'd0, 4'hA}); sb.push_back({2'd3, 4'h3});
        pulse_start(4'b1001);
        mask = 4'b0110;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6_done_seen");
        check("t6_beats", 32'(hs_cnt - hs0), 32'd2);
        check("t6_done_once", 32'(done_cnt - d0), 32'd1);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
